clint_irq_arb: RTL and testbench



---
 rtl/clint_irq_pkg.sv | 15 +
 rtl/clint_irq_core.sv | 110 +++++++++++
 rtl/clint_irq_arb.sv | 40 ++++
 tb/tb_clint_irq_arb.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_irq_pkg.sv
// Shared types and constants for the CLINT interrupt request stage.
// Optional synchronizer is enabled by defining CLINT_IRQ_SYNC_EN.
package clint_irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam int         CAUSE_W   = 4;
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;

endpackage

// File: rtl/clint_irq_core.sv
// One hart's request path: optional mtip/msip synchronizer, request FSM and cause register.
// The synchronizer exists only when CLINT_IRQ_SYNC_EN is defined.
module clint_irq_core
    import clint_irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mtip,
    input  logic               msip,
    input  logic               mstatus_mie,
    input  logic               mie_msie,
    input  logic               mie_mtie,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic               irq_valid,
    output logic [CAUSE_W-1:0] irq_cause
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("clint_irq_core: SYNC_STAGES must be in 2..4");
    end

    logic mtip_s;
    logic msip_s;

`ifdef CLINT_IRQ_SYNC_EN
    logic [SYNC_STAGES-1:0] mtip_sync_q, mtip_sync_d;
    logic [SYNC_STAGES-1:0] msip_sync_q, msip_sync_d;

    always_comb begin
        mtip_sync_d = {mtip_sync_q[SYNC_STAGES-2:0], mtip};
        msip_sync_d = {msip_sync_q[SYNC_STAGES-2:0], msip};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtip_sync_q <= '0;
            msip_sync_q <= '0;
        end else begin
            mtip_sync_q <= mtip_sync_d;
            msip_sync_q <= msip_sync_d;
        end
    end

    assign mtip_s = mtip_sync_q[SYNC_STAGES-1];
    assign msip_s = msip_sync_q[SYNC_STAGES-1];
`else
    assign mtip_s = mtip;
    assign msip_s = msip;
`endif

    logic sw;
    logic tm;

    assign sw = msip_s & mie_msie & mstatus_mie;
    assign tm = mtip_s & mie_mtie & mstatus_mie;

    irq_state_t         state_q, state_d;
    logic               valid_q, valid_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;

    // Sources are only looked at in IDLE, so a handler clearing its source cannot re-trigger.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (sw) begin
                    state_d = REQ;
                    cause_d = CAUSE_MSI;
                end else if (tm) begin
                    state_d = REQ;
                    cause_d = CAUSE_MTI;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (irq_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        valid_d = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            cause_q <= cause_d;
        end
    end

    assign irq_valid = valid_q;
    assign irq_cause = cause_q;

endmodule

// File: rtl/clint_irq_arb.sv
// Per-hart interrupt request stage downstream of the CLINT; one independent core per hart.
// Define CLINT_IRQ_SYNC_EN to synchronize mtip/msip through SYNC_STAGES flops.
module clint_irq_arb
    import clint_irq_pkg::*;
#(
    parameter int N_CORES     = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_CORES-1:0]           mtip,
    input  logic [N_CORES-1:0]           msip,
    input  logic [N_CORES-1:0]           mstatus_mie,
    input  logic [N_CORES-1:0]           mie_msie,
    input  logic [N_CORES-1:0]           mie_mtie,
    output logic [N_CORES-1:0]           irq_valid,
    output logic [CAUSE_W*N_CORES-1:0]   irq_cause,
    input  logic [N_CORES-1:0]           irq_ack,
    input  logic [N_CORES-1:0]           irq_done
);

    for (genvar k = 0; k < N_CORES; k++) begin : g_hart
        clint_irq_core #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_core (
            .clk        (clk),
            .reset      (reset),
            .mtip       (mtip[k]),
            .msip       (msip[k]),
            .mstatus_mie(mstatus_mie[k]),
            .mie_msie   (mie_msie[k]),
            .mie_mtie   (mie_mtie[k]),
            .irq_ack    (irq_ack[k]),
            .irq_done   (irq_done[k]),
            .irq_valid  (irq_valid[k]),
            .irq_cause  (irq_cause[CAUSE_W*k +: CAUSE_W])
        );
    end

endmodule

// File: tb/tb_clint_irq_arb.sv
// Directed and randomized checks of clint_irq_arb against a cycle-level behavioural model.
// Latency expectations follow CLINT_IRQ_SYNC_EN when it is defined for the build.
module tb_clint_irq_arb;

    localparam int N    = 2;
    localparam int SYNC = 2;
`ifdef CLINT_IRQ_SYNC_EN
    localparam int DLY = SYNC;
`else
    localparam int DLY = 0;
`endif
    localparam int LAT = DLY + 1;

    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_SVC  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     mtip, msip, mstatus_mie, mie_msie, mie_mtie;
    logic [N-1:0]     irq_valid, irq_ack, irq_done;
    logic [4*N-1:0]   irq_cause;

    int n_assert = 0;
    int n_fail   = 0;

    int           m_state[N];
    int           m_cause[N];
    logic [N-1:0] hist_sw[$];
    logic [N-1:0] hist_tm[$];

    clint_irq_arb #(
        .N_CORES    (N),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mtip       (mtip),
        .msip       (msip),
        .mstatus_mie(mstatus_mie),
        .mie_msie   (mie_msie),
        .mie_mtie   (mie_mtie),
        .irq_valid  (irq_valid),
        .irq_cause  (irq_cause),
        .irq_ack    (irq_ack),
        .irq_done   (irq_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The CLINT levels seen by the decision lag the pins by DLY edges; reset clears that history.
    task automatic model_reset();
        hist_sw.delete();
        hist_tm.delete();
        for (int i = 0; i < DLY; i++) begin
            hist_sw.push_front('0);
            hist_tm.push_front('0);
        end
        for (int k = 0; k < N; k++) begin
            m_state[k] = M_IDLE;
            m_cause[k] = 0;
        end
    endtask

    task automatic model_step();
        logic [N-1:0] es, et;
        hist_sw.push_front(msip);
        hist_tm.push_front(mtip);
        while (hist_sw.size() > DLY + 1) begin
            void'(hist_sw.pop_back());
            void'(hist_tm.pop_back());
        end
        es = hist_sw[DLY];
        et = hist_tm[DLY];
        for (int k = 0; k < N; k++) begin
            if (m_state[k] == M_IDLE) begin
                if (es[k] && mie_msie[k] && mstatus_mie[k]) begin
                    m_state[k] = M_REQ;
                    m_cause[k] = 3;
                end else if (et[k] && mie_mtie[k] && mstatus_mie[k]) begin
                    m_state[k] = M_REQ;
                    m_cause[k] = 7;
                end
            end else if (m_state[k] == M_REQ) begin
                if (irq_ack[k]) m_state[k] = M_SVC;
            end else begin
                if (irq_done[k]) m_state[k] = M_IDLE;
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < N; k++) begin
            check($sformatf("model_valid[%0d]", k), 32'(irq_valid[k]), 32'(m_state[k] == M_REQ));
            check($sformatf("model_cause[%0d]", k), 32'(irq_cause[4*k +: 4]), 32'(m_cause[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic drain();
        msip     = '0;
        mtip     = '0;
        irq_ack  = '0;
        irq_done = '0;
        repeat (LAT + 2) tick();
        irq_ack = '1;
        tick();
        irq_ack  = '0;
        irq_done = '1;
        tick();
        irq_done = '0;
        repeat (LAT + 2) tick();
        check("drain_idle", 32'(irq_valid), 32'(0));
    endtask

    initial begin
        reset       = 1'b0;
        mtip        = '0;
        msip        = '0;
        mstatus_mie = '0;
        mie_msie    = '0;
        mie_mtie    = '0;
        irq_ack     = '0;
        irq_done    = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(irq_valid), 32'(0));
        check("reset_cause", 32'(irq_cause), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Timer request on hart 0, then ack.
        mstatus_mie = '1;
        mie_msie    = '1;
        mie_mtie    = '1;
        mtip[0]     = 1'b1;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            if (i < LAT) check("latency_low", 32'(irq_valid[0]), 32'(0));
        end
        check("tm_valid", 32'(irq_valid[0]), 32'(1));
        check("tm_cause", 32'(irq_cause[3:0]), 32'(7));
        irq_ack[0] = 1'b1;
        tick();
        irq_ack[0] = 1'b0;
        check("ack_drops_valid", 32'(irq_valid[0]), 32'(0));
        drain();

        // Software beats timer; still-pending timer re-requests two edges after done.
        msip[0] = 1'b1;
        mtip[0] = 1'b1;
        repeat (LAT) tick();
        check("sw_prio_valid", 32'(irq_valid[0]), 32'(1));
        check("sw_prio_cause", 32'(irq_cause[3:0]), 32'(3));
        msip[0] = 1'b0;
        repeat (LAT) tick();
        irq_ack[0] = 1'b1;
        tick();
        irq_ack[0]  = 1'b0;
        irq_done[0] = 1'b1;
        tick();
        irq_done[0] = 1'b0;
        check("done_edge1_low", 32'(irq_valid[0]), 32'(0));
        tick();
        check("rereq_valid", 32'(irq_valid[0]), 32'(1));
        check("rereq_cause", 32'(irq_cause[3:0]), 32'(7));
        drain();

        // Disabled timer stays quiet; enabling it fires one edge later.
        mie_mtie[0] = 1'b0;
        mtip[0]     = 1'b1;
        repeat (20) tick();
        check("disabled_quiet", 32'(irq_valid[0]), 32'(0));
        mie_mtie[0] = 1'b1;
        tick();
        check("enable_fires", 32'(irq_valid[0]), 32'(1));
        check("enable_cause", 32'(irq_cause[3:0]), 32'(7));
        drain();

        // Request is held after source and enables drop.
        msip[0] = 1'b1;
        repeat (LAT) tick();
        msip        = '0;
        mstatus_mie = '0;
        mie_msie    = '0;
        mie_mtie    = '0;
        repeat (5) tick();
        check("hold_valid", 32'(irq_valid[0]), 32'(1));
        check("hold_cause", 32'(irq_cause[3:0]), 32'(3));
        irq_ack[0] = 1'b1;
        tick();
        irq_ack[0] = 1'b0;
        check("hold_acked", 32'(irq_valid[0]), 32'(0));
        mstatus_mie = '1;
        mie_msie    = '1;
        mie_mtie    = '1;
        drain();

        // Hart isolation.
        mtip[1] = 1'b1;
        repeat (LAT) tick();
        check("hart1_only", 32'(irq_valid), 32'(2'b10));
        irq_ack[0] = 1'b1;
        tick();
        irq_ack[0]  = 1'b0;
        irq_done[0] = 1'b1;
        tick();
        irq_done[0] = 1'b0;
        check("hart1_unaffected", 32'(irq_valid), 32'(2'b10));
        check("hart1_cause", 32'(irq_cause[7:4]), 32'(7));
        drain();

        // Asynchronous reset with hart 0 in SERVICE and hart 1 in REQ.
        mtip = '1;
        repeat (LAT) tick();
        irq_ack[0] = 1'b1;
        tick();
        irq_ack[0] = 1'b0;
        check("pre_reset_valid", 32'(irq_valid), 32'(2'b10));
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(irq_valid), 32'(0));
        check("async_rst_cause", 32'(irq_cause), 32'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            if (i < LAT) check("post_rst_low", 32'(irq_valid), 32'(0));
        end
        check("post_rst_valid", 32'(irq_valid), 32'(2'b11));
        drain();

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 7) == 0) msip[k] = ~msip[k];
                if ($urandom_range(0, 5) == 0) mtip[k] = ~mtip[k];
                mstatus_mie[k] = ($urandom_range(0, 9) != 0);
                mie_msie[k]    = ($urandom_range(0, 5) != 0);
                mie_mtie[k]    = ($urandom_range(0, 5) != 0);
                irq_ack[k]     = ($urandom_range(0, 3) == 0);
                irq_done[k]    = ($urandom_range(0, 4) == 0);
            end
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
